rram_wb_initiator: RTL and testbench

//  Wishbone initiator that drives the RRAM in-memory-compute top level from a command stream.
//  It executes four command types: register write, register read, start pulse and FIFO drain.
//  It generates start_operation and the ADC/CSA output-FIFO read strobes, and returns read data on a response channel.
//  It sits between the host-side sequencer/test harness and the RRAM controller's Wishbone target port.

---
 rtl/rram_wb_initiator_pkg.sv | 23 ++
 rtl/rram_wb_timeout_ctr.sv | 36 +++
 rtl/rram_wb_initiator.sv | 211 +++++++++++++++++++++
 tb/tb_rram_wb_initiator.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rram_wb_initiator_pkg.sv
// Shared encodings for the RRAM Wishbone initiator: command opcodes, FSM states, DRAIN select bit.
package rram_wb_initiator_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_START = 2'b10,
    OP_DRAIN = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_START_PULSE,
    ST_POP,
    ST_WAIT,
    ST_RESP
  } state_e;

  // cmd_data bit choosing the CSA (1) or ADC (0) output FIFO for DRAIN
  localparam int DRAIN_SEL_BIT = 8;

endpackage

// File: rtl/rram_wb_timeout_ctr.sv
// Wait-cycle counter: cleared by load, counts while enabled, expired on the TIMEOUT-th enabled cycle.
// Saturates at expiry so a stalled bus keeps reporting expired until reloaded.
module rram_wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rram_wb_initiator.sv
// Wishbone initiator executing WRITE/READ/START/DRAIN commands against the RRAM controller.
// One command in flight; all outputs registered; a pending response stalls everything until rsp_ready.
module rram_wb_initiator
  import rram_wb_initiator_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int POP_LAT = 2,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              start_operation,
  output logic              rd_sync_fifo_output_buffer_ADC,
  output logic              rd_sync_fifo_output_buffer_CSA
);

  localparam int LW = (POP_LAT < 2) ? 1 : $clog2(POP_LAT);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              sel_csa_q, sel_csa_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_last_q, rsp_last_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic              start_q, start_d;
  logic              rd_adc_q, rd_adc_d;
  logic              rd_csa_q, rd_csa_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              cmd_ready_q, cmd_ready_d;

  logic accept;
  logic expired;

  assign accept = cmd_valid && cmd_ready_q;

  rram_wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q != ST_WB_REQ),
    .enable  (state_q == ST_WB_REQ),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE, OP_READ: state_d = ST_WB_REQ;
            OP_START:          state_d = ST_START_PULSE;
            default:           state_d = (cmd_data[CNT_W-1:0] != '0) ? ST_POP : ST_RESP;
          endcase
        end
      end
      ST_WB_REQ:      if (wbm_ack_i || expired) state_d = ST_RESP;
      ST_START_PULSE: state_d = ST_RESP;
      ST_POP:         state_d = (POP_LAT <= 1) ? ST_WB_REQ : ST_WAIT;
      ST_WAIT:        if (lat_q == LW'(1)) state_d = ST_WB_REQ;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = (op_q == OP_DRAIN && rem_q != '0 && !rsp_err_q) ? ST_POP : ST_IDLE;
        end
      end
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    sel_csa_d  = sel_csa_q;
    rem_d      = rem_q;
    lat_d      = lat_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_last_d = rsp_last_q;

    if (state_q == ST_IDLE && accept) begin
      op_d       = op_e'(cmd_op);
      adr_d      = cmd_addr;
      wdat_d     = cmd_data;
      sel_csa_d  = cmd_data[DRAIN_SEL_BIT];
      rem_d      = cmd_data[CNT_W-1:0];
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
      rsp_last_d = 1'b1;
    end

    // rem counts words not yet popped, so it reads 0 while the final word is in flight
    if (state_q == ST_POP) begin
      rem_d = rem_q - 1'b1;
      lat_d = LW'(POP_LAT - 1);
    end
    if (state_q == ST_WAIT) begin
      lat_d = lat_q - 1'b1;
    end

    // ack beats a coincident timeout
    if (state_q == ST_WB_REQ) begin
      if (wbm_ack_i) begin
        rsp_data_d = (op_q == OP_WRITE) ? '0 : wbm_dat_i;
        rsp_err_d  = 1'b0;
        rsp_last_d = (op_q != OP_DRAIN) || (rem_q == '0);
      end else if (expired) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        rsp_last_d = 1'b1;
      end
    end

    cyc_d       = (state_d == ST_WB_REQ);
    we_d        = cyc_d && (op_d == OP_WRITE);
    start_d     = (state_d == ST_START_PULSE);
    rd_csa_d    = (state_d == ST_POP) && sel_csa_d;
    rd_adc_d    = (state_d == ST_POP) && !sel_csa_d;
    rsp_valid_d = (state_d == ST_RESP);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OP_WRITE;
      adr_q       <= '0;
      wdat_q      <= '0;
      sel_csa_q   <= 1'b0;
      rem_q       <= '0;
      lat_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      start_q     <= 1'b0;
      rd_adc_q    <= 1'b0;
      rd_csa_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      op_q        <= op_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      sel_csa_q   <= sel_csa_d;
      rem_q       <= rem_d;
      lat_q       <= lat_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      start_q     <= start_d;
      rd_adc_q    <= rd_adc_d;
      rd_csa_q    <= rd_csa_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready                      = cmd_ready_q;
  assign rsp_valid                      = rsp_valid_q;
  assign rsp_data                       = rsp_data_q;
  assign rsp_err                        = rsp_err_q;
  assign rsp_last                       = rsp_last_q;
  assign wbm_cyc_o                      = cyc_q;
  assign wbm_stb_o                      = cyc_q;
  assign wbm_we_o                       = we_q;
  assign wbm_adr_o                      = adr_q;
  assign wbm_dat_o                      = wdat_q;
  assign wbm_sel_o                      = {4{cyc_q}};
  assign start_operation                = start_q;
  assign rd_sync_fifo_output_buffer_ADC = rd_adc_q;
  assign rd_sync_fifo_output_buffer_CSA = rd_csa_q;

endmodule

// File: tb/tb_rram_wb_initiator.sv
// Directed bench for rram_wb_initiator with a behavioural Wishbone target and output monitors.
module tb_rram_wb_initiator;

  localparam int TB_POP_LAT = 2;
  localparam int TB_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        start_operation;
  logic        rd_adc, rd_csa;

  int total = 0;
  int bad = 0;

  initial forever #5 clk = ~clk;

  rram_wb_initiator dut (
    .clk                            (clk),
    .rst                            (rst),
    .cmd_valid                      (cmd_valid),
    .cmd_ready                      (cmd_ready),
    .cmd_op                         (cmd_op),
    .cmd_addr                       (cmd_addr),
    .cmd_data                       (cmd_data),
    .rsp_valid                      (rsp_valid),
    .rsp_ready                      (rsp_ready),
    .rsp_data                       (rsp_data),
    .rsp_err                        (rsp_err),
    .rsp_last                       (rsp_last),
    .wbm_cyc_o                      (wbm_cyc_o),
    .wbm_stb_o                      (wbm_stb_o),
    .wbm_we_o                       (wbm_we_o),
    .wbm_adr_o                      (wbm_adr_o),
    .wbm_dat_o                      (wbm_dat_o),
    .wbm_sel_o                      (wbm_sel_o),
    .wbm_dat_i                      (wbm_dat_i),
    .wbm_ack_i                      (wbm_ack_i),
    .start_operation                (start_operation),
    .rd_sync_fifo_output_buffer_ADC (rd_adc),
    .rd_sync_fifo_output_buffer_CSA (rd_csa)
  );

  // Target: acks on the ack_after-th cycle of a bus cycle; data fixed or a 1,2,3.. sequence
  logic        ack_on = 1'b1;
  int          ack_after = 1;
  logic        rd_inc = 1'b0;
  logic [31:0] rd_base = '0;
  int          ack_ref = 0;
  int          ack_num = 0;
  int          cyc_run = 0;

  initial forever begin
    @(negedge clk);
    if (wbm_cyc_o && wbm_stb_o) begin
      cyc_run++;
      if (ack_on && cyc_run == ack_after) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = rd_inc ? 32'(ack_num - ack_ref + 1) : rd_base;
        ack_num++;
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
      end
    end else begin
      cyc_run   = 0;
      wbm_ack_i = 1'b0;
      wbm_dat_i = '0;
    end
  end

  // Activity counters; tests compare deltas taken while the bus is quiet
  int   n_cyc = 0, n_we = 0, n_sel_bad = 0, n_start = 0, n_adc = 0, n_csa = 0, n_both = 0;
  int   n_gap = 0, n_gap_bad = 0, cyc_idx = 0, last_strobe = 0;
  logic prev_cyc = 1'b0, strobe_pend = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc_idx++;
    if (wbm_cyc_o) begin
      n_cyc++;
      if (wbm_sel_o !== 4'hF || wbm_stb_o !== 1'b1) n_sel_bad++;
    end
    if (wbm_we_o) n_we++;
    if (start_operation) n_start++;
    if (rd_adc) n_adc++;
    if (rd_csa) n_csa++;
    if (rd_adc && rd_csa) n_both++;
    if (rd_adc || rd_csa) begin
      strobe_pend = 1'b1;
      last_strobe = cyc_idx;
    end
    if (wbm_cyc_o && !prev_cyc && strobe_pend) begin
      n_gap++;
      if (cyc_idx - last_strobe != TB_POP_LAT) n_gap_bad++;
      strobe_pend = 1'b0;
    end
    prev_cyc = wbm_cyc_o;
  end

  function automatic logic any_out();
    return |{cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last, wbm_cyc_o, wbm_stb_o, wbm_we_o,
             wbm_adr_o, wbm_dat_o, wbm_sel_o, start_operation, rd_adc, rd_csa};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL cmd_accept: cmd_ready stayed %b for %0d cycles, required 1", cmd_ready, n);
    end
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b10; cmd_addr = '1; cmd_data = '1;
  endtask

  task automatic wait_valid(output int w);
    w = 0;
    while (rsp_valid !== 1'b1 && w < 1000) begin
      tick();
      w++;
    end
    if (w >= 1000) begin
      total++; bad++;
      $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, w);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++;
    if (any_out() !== 1'b0) $display("FAIL reset_async: outputs nonzero=%b required 0", any_out());
    if (any_out() !== 1'b0) bad++;
    tick(); tick();
    total++;
    if (any_out() !== 1'b0) begin bad++; $display("FAIL reset_hold: outputs nonzero=%b required 0", any_out()); end
    rst = 1'b0;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_write();
    int w, c0, we0, s0;
    ack_on = 1'b1; ack_after = 3;
    c0 = n_cyc; we0 = n_we; s0 = n_sel_bad;
    send_cmd(2'b00, 32'h3000_0004, 32'hA5A5_0001);
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'b111_1111 || wbm_adr_o !== 32'h3000_0004
        || wbm_dat_o !== 32'hA5A5_0001) begin
      bad++; $display("FAIL write_bus: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h required 1 1 1 f 30000004 a5a50001",
                      wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
    end
    wait_valid(w);
    total++;
    if (w != 3) begin bad++; $display("FAIL write_latency: %0d cycles required 3", w); end
    total++;
    if (rsp_err !== 1'b0 || rsp_last !== 1'b1 || rsp_data !== 32'h0) begin
      bad++; $display("FAIL write_rsp: err=%b last=%b data=%h required 0 1 0", rsp_err, rsp_last, rsp_data);
    end
    handshake();
    total++;
    if (n_cyc - c0 != 3 || n_we - we0 != 3 || n_sel_bad != s0) begin
      bad++; $display("FAIL write_cycles: cyc=%0d we=%0d selbad=%0d required 3 3 0", n_cyc - c0, n_we - we0, n_sel_bad - s0);
    end
  endtask

  task automatic test_read();
    int w, c0, we0;
    ack_on = 1'b1; ack_after = 1; rd_inc = 1'b0; rd_base = 32'h0000_BEEF;
    c0 = n_cyc; we0 = n_we;
    send_cmd(2'b01, 32'h3000_0010, 32'h0);
    wait_valid(w);
    total++;
    if (w != 1) begin bad++; $display("FAIL read_latency: %0d cycles required 1", w); end
    total++;
    if (rsp_data !== 32'h0000_BEEF || rsp_err !== 1'b0 || rsp_last !== 1'b1) begin
      bad++; $display("FAIL read_rsp: data=%h err=%b last=%b required 0000beef 0 1", rsp_data, rsp_err, rsp_last);
    end
    handshake();
    total++;
    if (n_we != we0 || n_cyc - c0 != 1) begin
      bad++; $display("FAIL read_bus: we_cycles=%0d cyc_cycles=%0d required 0 1", n_we - we0, n_cyc - c0);
    end
  endtask

  task automatic test_start();
    int w, c0, st0;
    c0 = n_cyc; st0 = n_start;
    send_cmd(2'b10, 32'h0, 32'hFFFF_FFFF);
    wait_valid(w);
    total++;
    if (rsp_data !== 32'h0 || rsp_err !== 1'b0 || rsp_last !== 1'b1) begin
      bad++; $display("FAIL start_rsp: data=%h err=%b last=%b required 0 0 1", rsp_data, rsp_err, rsp_last);
    end
    handshake();
    repeat (3) tick();
    total++;
    if (n_start - st0 != 1 || n_cyc != c0) begin
      bad++; $display("FAIL start_pulse: pulses=%0d cyc_cycles=%0d required 1 0", n_start - st0, n_cyc - c0);
    end
  endtask

  task automatic test_drain_csa();
    int w, a0, c0, b0, g0, gb0;
    ack_on = 1'b1; ack_after = 1; rd_inc = 1'b1; ack_ref = ack_num;
    a0 = n_adc; c0 = n_csa; b0 = n_both; g0 = n_gap; gb0 = n_gap_bad;
    send_cmd(2'b11, 32'h3000_0020, 32'h0000_0104);
    for (int k = 1; k <= 4; k++) begin
      wait_valid(w);
      total++;
      if (rsp_data !== 32'(k) || rsp_err !== 1'b0 || rsp_last !== (k == 4)) begin
        bad++; $display("FAIL drain_rsp%0d: data=%h err=%b last=%b required %h 0 %b", k, rsp_data, rsp_err, rsp_last, k, k == 4);
      end
      if (k == 2) begin
        repeat (5) tick();
        total++;
        if (n_csa - c0 != 2 || rsp_valid !== 1'b1 || rsp_data !== 32'h2) begin
          bad++; $display("FAIL drain_backpressure: strobes=%0d valid=%b data=%h required 2 1 2", n_csa - c0, rsp_valid, rsp_data);
        end
      end
      handshake();
    end
    repeat (10) tick();
    total++;
    if (n_csa - c0 != 4 || n_adc != a0 || n_both != b0) begin
      bad++; $display("FAIL drain_strobes: csa=%0d adc=%0d both=%0d required 4 0 0", n_csa - c0, n_adc - a0, n_both - b0);
    end
    total++;
    if (n_gap - g0 != 4 || n_gap_bad != gb0) begin
      bad++; $display("FAIL drain_pop_lat: reads=%0d wrong_gap=%0d required 4 0", n_gap - g0, n_gap_bad - gb0);
    end
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL drain_end: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_drain_empty();
    int w, a0, c0;
    a0 = n_adc; c0 = n_csa;
    send_cmd(2'b11, 32'h3000_0020, 32'h0000_0100);
    wait_valid(w);
    total++;
    if (rsp_data !== 32'h0 || rsp_err !== 1'b0 || rsp_last !== 1'b1) begin
      bad++; $display("FAIL drain0_rsp: data=%h err=%b last=%b required 0 0 1", rsp_data, rsp_err, rsp_last);
    end
    handshake();
    repeat (4) tick();
    total++;
    if (n_adc != a0 || n_csa != c0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL drain0_quiet: adc=%0d csa=%0d valid=%b required 0 0 0", n_adc - a0, n_csa - c0, rsp_valid);
    end
  endtask

  task automatic test_timeout();
    int w, c0, a0;
    ack_on = 1'b0;
    c0 = n_cyc;
    send_cmd(2'b01, 32'h3000_0010, 32'h0);
    wait_valid(w);
    total++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_last !== 1'b1) begin
      bad++; $display("FAIL timeout_rsp: err=%b data=%h last=%b required 1 0 1", rsp_err, rsp_data, rsp_last);
    end
    total++;
    if (n_cyc - c0 != TB_TIMEOUT || wbm_cyc_o !== 1'b0) begin
      bad++; $display("FAIL timeout_cycles: cyc_cycles=%0d cyc=%b required %0d 0", n_cyc - c0, wbm_cyc_o, TB_TIMEOUT);
    end
    handshake();
    a0 = n_adc; c0 = n_cyc;
    send_cmd(2'b11, 32'h3000_0024, 32'h0000_0003);
    wait_valid(w);
    total++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_last !== 1'b1) begin
      bad++; $display("FAIL timeout_drain_rsp: err=%b data=%h last=%b required 1 0 1", rsp_err, rsp_data, rsp_last);
    end
    handshake();
    repeat (20) tick();
    total++;
    if (n_adc - a0 != 1 || n_cyc - c0 != TB_TIMEOUT || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL timeout_drain_end: pops=%0d cyc_cycles=%0d valid=%b ready=%b required 1 %0d 0 1",
                      n_adc - a0, n_cyc - c0, rsp_valid, cmd_ready, TB_TIMEOUT);
    end
    ack_on = 1'b1;
  endtask

  task automatic test_reset_midcycle();
    int n, w;
    ack_on = 1'b1; ack_after = 50; rd_inc = 1'b0;
    send_cmd(2'b11, 32'h3000_0020, 32'h0000_0102);
    n = 0;
    while (wbm_cyc_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (wbm_cyc_o !== 1'b1) begin bad++; $display("FAIL midreset_setup: cyc=%b required 1", wbm_cyc_o); end
    #1 rst = 1'b1;
    #1;
    total++;
    if (any_out() !== 1'b0) begin bad++; $display("FAIL midreset_async: outputs nonzero=%b required 0", any_out()); end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      bad++; $display("FAIL midreset_release: ready=%b valid=%b cyc=%b required 1 0 0", cmd_ready, rsp_valid, wbm_cyc_o);
    end
    ack_after = 2; rd_base = 32'h1234_5678;
    send_cmd(2'b01, 32'h3000_0014, 32'h0);
    wait_valid(w);
    total++;
    if (w != 2 || rsp_data !== 32'h1234_5678 || rsp_err !== 1'b0 || rsp_last !== 1'b1) begin
      bad++; $display("FAIL midreset_read: lat=%0d data=%h err=%b last=%b required 2 12345678 0 1", w, rsp_data, rsp_err, rsp_last);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_start();
    test_drain_csa();
    test_drain_empty();
    test_timeout();
    test_reset_midcycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
